oam_dma_ctrl: RTL and testbench
===============================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, single clock domain, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: cpu_ab  in  16  CPU address bus.
REQ-004 SHALL have ports: cpu_dout  in  8  CPU write data.
REQ-005 SHALL have ports: cpu_we  in  1  CPU write strobe, one cycle per write.
REQ-006 SHALL have ports: cpu_rdy  out  1  0 halts the CPU.
REQ-007 SHALL have ports: dma_active  out  1  1 while the DMA owns the bus.
REQ-008 SHALL have ports: dma_ab  out  16  DMA-driven address.
REQ-009 SHALL have ports: dma_din  in  8  read data returned for dma_ab.
REQ-010 SHALL have ports: dma_dout  out  8  DMA write data.
REQ-011 SHALL have ports: dma_rd  out  1  DMA read strobe.
REQ-012 SHALL have ports: dma_we  out  1  DMA write strobe.

Function
REQ-013 SHALL trigger when cpu_we=1 and cpu_ab=16'h4014 are sampled in IDLE; SHALL latch cpu_dout as page P.
REQ-014 SHALL implement states IDLE, HALT, ALIGN, READ and WRITE.
REQ-015 SHALL apply transitions: IDLE->HALT on trigger; HALT->ALIGN if ALIGN is enabled and parity=1, else HALT->READ; ALIGN->READ; READ->WRITE; WRITE->READ if idx!=8'hFF, else WRITE->IDLE.
REQ-016 SHALL hold an 8-bit idx that clears on trigger, increments on each WRITE exit and wraps FF->00 only on completion.
REQ-017 SHALL drive cpu_rdy=0 and dma_active=1 in every non-IDLE state, starting the cycle after the trigger; SHALL restore cpu_rdy=1 the cycle after the final WRITE.
REQ-018 SHALL, in READ, drive dma_ab={P,idx} and dma_rd=1; SHALL capture dma_din into a byte register at the READ-ending edge.
REQ-019 SHALL, in WRITE, drive dma_ab=16'h2004, dma_dout=captured byte and dma_we=1.
REQ-020 SHALL drive dma_rd=dma_we=0 and dma_ab=16'h0000 in IDLE, HALT and ALIGN.
REQ-021 SHALL halt the CPU for exactly 513 cycles without ALIGN, or 514 cycles with ALIGN when parity=1 in HALT.
REQ-022 SHALL hold a parity flop that resets to 0 and toggles every clk regardless of state.
REQ-023 SHALL ignore a write to 16'h4014 while not in IDLE; P SHALL be unchanged.
REQ-024 SHALL not trigger on writes to other addresses or on reads of 16'h4014.
REQ-025 SHALL trigger again on a write to 16'h4014 in the first IDLE cycle after completion.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, enter IDLE with idx=0, P=0, byte=0, parity=0, cpu_rdy=1, dma_active=0, dma_rd=0, dma_we=0, dma_ab=0 and dma_dout=0.
REQ-027 SHALL, on rst mid-transfer, abort with no further dma_we pulses; cpu_rdy=1 SHALL hold from the next cycle.
REQ-028 SHALL give rst priority over a simultaneous trigger.

Configuration
REQ-029 SHALL compile the ALIGN state and its parity-dependent path only when OAM_DMA_ODD_ALIGN_EN is defined.
REQ-030 SHALL, without OAM_DMA_ODD_ALIGN_EN, go HALT->READ unconditionally; the transfer SHALL always be 513 cycles and the parity flop MAY be omitted.

Structure
REQ-031 SHALL place these items in shared package nes_pkg: OAM_DMA_ADDR=16'h4014, OAMDATA_ADDR=16'h2004, and the enumerated typedef oam_dma_state_t.
REQ-032 SHALL contain one sub-module, oam_dma_trigger, which decodes the trigger and latches the page; the FSM, counter and datapath SHALL remain in oam_dma_ctrl.

Verification
REQ-033 SHALL cover: write 8'h02 to 16'h4014 -> 256 reads at 16'h0200..16'h02FF, each followed by a write to 16'h2004 with the read byte; cpu_rdy=0 for 513 or 514 cycles.
REQ-034 SHALL cover: with OAM_DMA_ODD_ALIGN_EN, trigger so HALT has parity=1 -> 514 halt cycles; trigger so HALT has parity=0 -> 513 halt cycles.
REQ-035 SHALL cover: memory byte = low address byte XOR 8'hA5, page 8'h07 -> dma_dout sequence A5,A4,A7,... ending in 5A; exactly 256 dma_we pulses.
REQ-036 SHALL cover: write 8'h03 to 16'h4014 during transfer of page 8'h02 -> ignored; all reads stay on page 8'h02.
REQ-037 SHALL cover: rst asserted at the 100th halt cycle -> next cycle cpu_rdy=1, dma_we=0, state IDLE; a new trigger then runs a full transfer.
REQ-038 SHALL cover: write to 16'h4015, and a read of 16'h4014 -> no trigger; cpu_rdy stays 1.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES definitions: register addresses and the OAM DMA state type.
// The ALIGN state only exists when OAM_DMA_ODD_ALIGN_EN is defined.
package nes_pkg;

  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  localparam logic [7:0]  LAST_IDX     = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
`ifdef OAM_DMA_ODD_ALIGN_EN
    ST_ALIGN = 3'd2,
`endif
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_trigger.sv
// Decodes a CPU write to the OAM DMA register while idle and latches the
// source page; writes seen while a transfer is running are dropped.
module oam_dma_trigger
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_cpu_ab,
  input  logic [7:0]  i_cpu_dout,
  input  logic        i_cpu_we,
  input  logic        i_idle,
  output logic        o_trig,
  output logic [7:0]  o_page
);

  logic [7:0] r_page;
  logic       w_trig;

  assign w_trig = i_idle & i_cpu_we & (i_cpu_ab == OAM_DMA_ADDR);

  always_ff @(posedge clk) begin
    if (rst)
      r_page <= 8'h00;
    else if (w_trig)
      r_page <= i_cpu_dout;
  end

  assign o_trig = w_trig;
  assign o_page = r_page;

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: halts the CPU and copies page P (256 bytes) to OAMDATA.
// Define OAM_DMA_ODD_ALIGN_EN to add the one-cycle ALIGN on odd-parity halts.
module oam_dma_ctrl
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_ab,
  input  logic [7:0]  dma_din,
  output logic [7:0]  dma_dout,
  output logic        dma_rd,
  output logic        dma_we
);

  oam_dma_state_t r_state, w_state_next;
  logic [7:0]     r_idx, r_byte, w_page;
  logic           w_trig, w_idle;

  assign w_idle = (r_state == ST_IDLE);

  oam_dma_trigger u_trigger (
    .clk        (clk),
    .rst        (rst),
    .i_cpu_ab   (cpu_ab),
    .i_cpu_dout (cpu_dout),
    .i_cpu_we   (cpu_we),
    .i_idle     (w_idle),
    .o_trig     (w_trig),
    .o_page     (w_page)
  );

`ifdef OAM_DMA_ODD_ALIGN_EN
  // Free-running cycle parity, independent of the transfer state.
  logic r_parity;
  always_ff @(posedge clk) begin
    if (rst)
      r_parity <= 1'b0;
    else
      r_parity <= ~r_parity;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_trig) w_state_next = ST_HALT;
`ifdef OAM_DMA_ODD_ALIGN_EN
      ST_HALT:  w_state_next = r_parity ? ST_ALIGN : ST_READ;
      ST_ALIGN: w_state_next = ST_READ;
`else
      ST_HALT:  w_state_next = ST_READ;
`endif
      ST_READ:  w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = (r_idx == LAST_IDX) ? ST_IDLE : ST_READ;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // idx wraps FF->00 only on the final WRITE, leaving it ready for the next run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= 8'h00;
      r_byte <= 8'h00;
    end else begin
      if (w_trig)
        r_idx <= 8'h00;
      else if (r_state == ST_WRITE)
        r_idx <= r_idx + 8'd1;
      if (r_state == ST_READ)
        r_byte <= dma_din;
    end
  end

  always_comb begin
    cpu_rdy    = w_idle;
    dma_active = ~w_idle;
    dma_ab     = 16'h0000;
    dma_dout   = 8'h00;
    dma_rd     = 1'b0;
    dma_we     = 1'b0;
    case (r_state)
      ST_READ: begin
        dma_ab = {w_page, r_idx};
        dma_rd = 1'b1;
      end
      ST_WRITE: begin
        dma_ab   = OAMDATA_ADDR;
        dma_dout = r_byte;
        dma_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl against a transfer-level reference model.
// Honours OAM_DMA_ODD_ALIGN_EN when computing the expected halt length.
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_rdy, dma_active, dma_rd, dma_we;
  logic [15:0] dma_ab;
  logic [7:0]  dma_din, dma_dout;

  logic [7:0]  mem [0:65535];
  bit          use_xor = 1'b0;
  int unsigned n_edges = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  oam_dma_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ab     (cpu_ab),
    .cpu_dout   (cpu_dout),
    .cpu_we     (cpu_we),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active),
    .dma_ab     (dma_ab),
    .dma_din    (dma_din),
    .dma_dout   (dma_dout),
    .dma_rd     (dma_rd),
    .dma_we     (dma_we)
  );

  function automatic logic [7:0] ref_mem(input logic [15:0] a);
    return use_xor ? (a[7:0] ^ 8'hA5) : mem[a];
  endfunction

  assign dma_din = ref_mem(dma_ab);

  // Edges since the last reset edge; its parity predicts the HALT-cycle parity.
  always @(posedge clk) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic noise_test();
    int busy;
    logic [15:0] a;
    busy = 0;
    @(negedge clk); cpu_ab = 16'h4015; cpu_dout = 8'h02; cpu_we = 1'b1;
    @(negedge clk); cpu_ab = 16'h4014; cpu_we = 1'b0;
    @(negedge clk);
    a = 16'($urandom);
    if (a == 16'h4014) a = 16'h4016;
    cpu_ab = a; cpu_dout = 8'($urandom); cpu_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_we = 1'b0;
      if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) busy++;
    end
    chk("no_trig", busy, 0);
    $display("noise: writes 4015/%04h and read 4014 -> busy cycles %0d", a, busy);
  endtask

  // Call at a negedge; triggers immediately and follows the transfer.
  task automatic do_xfer(input logic [7:0] page, input int ignore_at, input int rst_at);
    int halt, nrd, nwe, rd_err, wr_err, mode_err, exp_len, quiet;
    bit done;
    logic [7:0] exp_byte, first_wr, last_wr;
    halt = 0; nrd = 0; nwe = 0; rd_err = 0; wr_err = 0; mode_err = 0; done = 0;
    exp_byte = 8'h00; first_wr = 8'h00; last_wr = 8'h00;
    exp_len = 513 + ((ALIGN_EN && ((n_edges + 1) % 2 == 1)) ? 1 : 0);
    cpu_ab = 16'h4014; cpu_dout = page; cpu_we = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 1200; c++) begin
      cpu_we = 1'b0;
      if (cpu_rdy === 1'b1) begin
        done = 1'b1;
        break;
      end
      halt++;
      if (dma_active !== 1'b1 || (dma_rd && dma_we)) mode_err++;
      if (dma_rd === 1'b1) begin
        if (nrd != nwe) mode_err++;
        if (dma_ab !== {page, 8'(nrd)}) rd_err++;
        exp_byte = ref_mem({page, 8'(nrd)});
        nrd++;
      end else if (dma_we === 1'b1) begin
        if (nwe != nrd - 1) mode_err++;
        if (dma_ab !== 16'h2004 || dma_dout !== exp_byte) wr_err++;
        if (nwe == 0) first_wr = dma_dout;
        last_wr = dma_dout;
        nwe++;
      end else if (dma_ab !== 16'h0000) begin
        mode_err++;
      end
      if (halt == ignore_at) begin
        cpu_ab = 16'h4014; cpu_dout = page + 8'd1; cpu_we = 1'b1;
      end
      if (halt == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rdy", cpu_rdy, 1);
        chk("rst_we", dma_we, 0);
        chk("rst_active", dma_active, 0);
        chk("rst_ab", dma_ab, 0);
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (dma_we !== 1'b0 || cpu_rdy !== 1'b1) quiet++;
        end
        chk("post_rst_quiet", quiet, 0);
        $display("xfer page=%02h aborted by rst at halt cycle %0d, writes before=%0d", page, halt, nwe);
        return;
      end
      @(negedge clk);
    end
    chk("done", done, 1);
    chk("halt_len", halt, exp_len);
    chk("rd_cnt", nrd, 256);
    chk("we_cnt", nwe, 256);
    chk("rd_addr_err", rd_err, 0);
    chk("wr_data_err", wr_err, 0);
    chk("mode_err", mode_err, 0);
    if (use_xor) begin
      chk("xor_first", first_wr, 8'hA5);
      chk("xor_last", last_wr, 8'h5A);
    end
    $display("xfer page=%02h halt=%0d (exp %0d) rd=%0d we=%0d errs=%0d/%0d/%0d",
             page, halt, exp_len, nrd, nwe, rd_err, wr_err, mode_err);
  endtask

  initial begin
    rst = 1'b1; cpu_ab = 16'h0000; cpu_dout = 8'h00; cpu_we = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_rdy", cpu_rdy, 1);
    chk("reset_active", dma_active, 0);
    chk("reset_rd", dma_rd, 0);
    chk("reset_we", dma_we, 0);
    chk("reset_ab", dma_ab, 0);
    chk("reset_dout", dma_dout, 0);
    $display("reset: rdy=%0b active=%0b ab=%04h", cpu_rdy, dma_active, dma_ab);
    rst = 1'b0;
    @(negedge clk);

    noise_test();
    @(negedge clk);
    do_xfer(8'h02, -1, -1);

    // Trigger so the HALT cycle sees each parity value in turn.
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      if (((n_edges + 1) % 2) != p) @(negedge clk);
      do_xfer(8'($urandom), -1, -1);
    end

    use_xor = 1'b1;
    @(negedge clk);
    do_xfer(8'h07, -1, -1);
    use_xor = 1'b0;

    @(negedge clk);
    do_xfer(8'h02, 50, -1);

    // Back-to-back: the second trigger lands in the first IDLE cycle.
    @(negedge clk);
    do_xfer(8'($urandom), -1, -1);
    do_xfer(8'($urandom), -1, -1);

    @(negedge clk);
    do_xfer(8'($urandom), -1, 100);
    do_xfer(8'($urandom), -1, -1);

    for (int k = 0; k < 5; k++) begin
      noise_test();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_xfer(8'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 512)) : -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
